// File: rtl/writeback_unit_if.sv
// Memory-to-writeback result channel.
// Valid/ready handshake plus the register write payload.
interface writeback_unit_if #(
    parameter int WIDTH        = 24,
    parameter int VECTOR_WIDTH = 8,
    parameter int ADDRESSWIDTH = 4
);
    logic                                wb_valid;
    logic                                wb_ready;
    logic                                wb_regwrite;
    logic [ADDRESSWIDTH-1:0]             wb_address;
    logic [WIDTH-1:0]                    wb_data;
    logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  wb_data_v;
    logic                                wb_isvector;
    logic                                wb_vect_esc;
    logic [2:0]                          wb_index;

    modport master (
        output wb_valid, wb_regwrite, wb_address, wb_data,
        output wb_data_v, wb_isvector, wb_vect_esc, wb_index,
        input  wb_ready
    );

    modport slave (
        input  wb_valid, wb_regwrite, wb_address, wb_data,
        input  wb_data_v, wb_isvector, wb_vect_esc, wb_index,
        output wb_ready
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: in-order result queue, mode expansion onto the
// register-file write bus, and a pending-write scoreboard for decode.
module writeback_unit #(
    parameter int WIDTH        = 24,
    parameter int VECTOR_WIDTH = 8,
    parameter int ADDRESSWIDTH = 4,
    parameter int DEPTH        = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    writeback_unit_if.slave                    wb,
    input  logic                               commit_stall,
    output logic [ADDRESSWIDTH-1:0]            writeAddress,
    output logic [WIDTH-1:0]                   dataToSave,
    output logic [VECTOR_WIDTH-1:0][WIDTH-1:0] dataToSave_v,
    output logic                               writeEnable,
    output logic                               isvector_A,
    output logic                               vect_esc_A,
    output logic [2:0]                         index_A,
    input  logic [ADDRESSWIDTH-1:0]            rd1_address,
    input  logic [ADDRESSWIDTH-1:0]            rd2_address,
    input  logic                               rd_isvector,
    output logic                               busy1,
    output logic                               busy2,
    output logic [$clog2(DEPTH):0]             occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [ADDRESSWIDTH-1:0]            q_addr [DEPTH];
    logic [WIDTH-1:0]                   q_data [DEPTH];
    logic [VECTOR_WIDTH-1:0][WIDTH-1:0] q_data_v [DEPTH];
    logic                               q_isv [DEPTH];
    logic                               q_esc [DEPTH];
    logic [2:0]                         q_idx [DEPTH];
    logic [DEPTH-1:0]                   q_valid;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic push;
    logic pop;

    logic [WIDTH-1:0]                   nxt_data;
    logic [VECTOR_WIDTH-1:0][WIDTH-1:0] nxt_data_v;

    assign wb.wb_ready = (count != FULL);
    assign push        = wb.wb_valid && wb.wb_ready && wb.wb_regwrite;
    assign pop         = (count != '0) && !commit_stall;
    assign occupancy   = count;

    always_ff @(posedge clock) begin
        if (push) begin
            q_addr[tail]   <= wb.wb_address;
            q_data[tail]   <= wb.wb_data;
            q_data_v[tail] <= wb.wb_data_v;
            q_isv[tail]    <= wb.wb_isvector;
            q_esc[tail]    <= wb.wb_vect_esc;
            q_idx[tail]    <= wb.wb_index;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            q_valid <= '0;
        end else begin
            if (push) begin
                tail          <= tail + PW'(1);
                q_valid[tail] <= 1'b1;
            end
            if (pop) begin
                head          <= head + PW'(1);
                q_valid[head] <= 1'b0;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Expand the head entry's mode into scalar and lane data
    always_comb begin
        nxt_data   = '0;
        nxt_data_v = '0;
        unique case ({q_isv[head], q_esc[head]})
            2'b00: nxt_data = q_data[head];
            2'b10: nxt_data_v = q_data_v[head];
            2'b11: begin
                nxt_data = q_data[head];
                for (int l = 0; l < VECTOR_WIDTH; l++) begin
                    if (l == int'(q_idx[head])) begin
                        nxt_data_v[l] = q_data[head];
                    end
                end
            end
            default: begin
                nxt_data = q_data[head];
                for (int l = 0; l < VECTOR_WIDTH; l++) begin
                    nxt_data_v[l] = q_data[head];
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            writeEnable  <= 1'b0;
            writeAddress <= '0;
            dataToSave   <= '0;
            dataToSave_v <= '0;
            isvector_A   <= 1'b0;
            vect_esc_A   <= 1'b0;
            index_A      <= '0;
        end else if (pop) begin
            writeEnable  <= 1'b1;
            writeAddress <= q_addr[head];
            dataToSave   <= nxt_data;
            dataToSave_v <= nxt_data_v;
            isvector_A   <= q_isv[head];
            vect_esc_A   <= q_esc[head];
            index_A      <= q_idx[head];
        end else begin
            writeEnable <= 1'b0;
        end
    end

    // Any non-scalar mode lives in the vector register file
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_valid[i] && ((q_isv[i] | q_esc[i]) == rd_isvector)) begin
                if (q_addr[i] == rd1_address) busy1 = 1'b1;
                if (q_addr[i] == rd2_address) busy2 = 1'b1;
            end
        end
    end
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Writeback stage that produces every register-file write consumed by the decode stage: writeAddress, dataToSave, dataToSave_v, writeEnable, isvector_A, vect_esc_A and index_A.
- Accepts results from the memory stage over a valid/ready handshake and buffers them in an in-order queue.
- Retires one write per cycle, expanding broadcast and element modes into the vector write bus.
- Exposes a pending-write scoreboard so the hazard logic can stall decode on a register that is still queued.

Parameters:
- WIDTH, 24, scalar/lane data width
- VECTOR_WIDTH, 8, lanes per vector register
- ADDRESSWIDTH, 4, register address width
- DEPTH, 4, queue entries (power of 2, >=2)

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears queue and outputs
- wb_valid  in  1  memory stage offers a result
- wb_ready  out  1  unit can accept (= !full)
- wb_regwrite  in  1  result writes a register; 0 = accept and discard
- wb_address  in  ADDRESSWIDTH  destination register
- wb_data  in  WIDTH  scalar result
- wb_data_v  in  VECTOR_WIDTH*WIDTH  vector result, packed [VECTOR_WIDTH-1:0][WIDTH-1:0]
- wb_isvector  in  1  mode bit 1
- wb_vect_esc  in  1  mode bit 0
- wb_index  in  3  lane for element mode
- commit_stall  in  1  hold retirement this cycle (regfile port conflict)
- writeAddress  out  ADDRESSWIDTH  regfile write address
- dataToSave  out  WIDTH  scalar write data
- dataToSave_v  out  VECTOR_WIDTH*WIDTH  vector write data
- writeEnable  out  1  write strobe, one cycle per retired entry
- isvector_A  out  1  mode bit 1 of the retiring entry
- vect_esc_A  out  1  mode bit 0 of the retiring entry
- index_A  out  3  lane of the retiring entry
- rd1_address, rd2_address  in  ADDRESSWIDTH  registers decode is reading
- rd_isvector  in  1  decode reads the vector file
- busy1, busy2  out  1  matching write still queued
- occupancy  out  $clog2(DEPTH)+1  valid entries

Behaviour:
- Reset (async): queue empty, pointers 0, writeEnable=0, all write outputs 0, busy1/busy2=0, occupancy=0, wb_ready=1.
- Accept: on an edge with wb_valid && wb_ready. If wb_regwrite=1, the entry is pushed at tail. If wb_regwrite=0, it is consumed and not stored.
- wb_ready = (occupancy != DEPTH). There is no pass-through when full, even if a pop occurs in the same cycle.
- Retire: on each edge where the queue is non-empty and commit_stall=0:
  - The head pops into the registered outputs and writeEnable=1 for the following cycle.
  - Otherwise writeEnable=0 and the data outputs hold their last values.
- Latency: a result accepted at edge N into an empty queue gives writeEnable=1 during cycle N+1 → N+2. The register file captures it on the falling clock.
- Simultaneous push and pop: both occur and occupancy is unchanged. Pointers wrap modulo DEPTH.
- Mode expansion at retirement ({isvector,vect_esc}):
  - 00 scalar: dataToSave=data; dataToSave_v=0.
  - 10 vector: dataToSave_v=data_v; dataToSave=0.
  - 11 element: dataToSave=data; dataToSave_v lane[index]=data, other lanes 0.
  - 01 broadcast: every lane of dataToSave_v=data; dataToSave=data.
  - The mode bits and index are forwarded unchanged on isvector_A, vect_esc_A and index_A.
- Scoreboard (combinational from queue state): busy1=1 iff some stored entry, excluding the output register, has address==rd1_address and isvector==rd_isvector. busy2 is the same test against rd2_address.
  - Modes 10, 11 and 01 count as vector; mode 00 counts as scalar.
  - The entry currently on the write outputs is not busy, because the regfile write precedes the decode read.
- commit_stall held for many cycles: the queue fills, wb_ready drops, and no entry is lost or duplicated.
- Reset asserted mid-stream: pending entries are discarded and writeEnable is forced to 0 immediately, without waiting for a clock edge.

Test Plan:
- Reset, then push scalar addr=3 data=0x00ABCD mode 00 → next cycle writeEnable=1, writeAddress=3, dataToSave=0x00ABCD, dataToSave_v=0; following cycle writeEnable=0.
- Element push addr=5 index=6 data=0x000077 mode 11 → dataToSave_v lane6=0x000077, all other lanes 0, index_A=6, isvector_A=1, vect_esc_A=1.
- Broadcast push mode 01 data=0x000011 → all 8 lanes 0x000011; then a vector push mode 10 with lanes k=k+1 → lanes 1..8 in order.
- commit_stall=1 with 5 back-to-back pushes → wb_ready=0 after 4 pushes, occupancy=4. Release the stall → 4 writes in push order on consecutive cycles, then the 5th push is accepted.
- Queue addr=2 mode 00 under stall; rd1_address=2: rd_isvector=0 → busy1=1, rd_isvector=1 → busy1=0. After retirement, busy1=0.
- Push with wb_regwrite=0 → wb_ready stays 1, occupancy stays 0, no writeEnable. Assert reset with 3 entries queued → writeEnable=0 and occupancy=0 at once, with no writes after release.
